// File: rtl/rgb_ctrl_pkg.sv
// rtl/rgb_ctrl_pkg.sv - shared constants for the RGB color key controller
// Purpose: channel indices, key FSM state encoding, default timing and
//          the counter-width helper shared by rgb_color_ctrl and key_repeat_fsm.
// Ports: none (package).
package rgb_ctrl_pkg;

  // Channel index into key[], pending[] and the working/display registers.
  localparam int RED   = 0;
  localparam int BLUE  = 1;
  localparam int GREEN = 2;

  // Key FSM state encoding.
  typedef logic [2:0] key_state_t;
  localparam key_state_t ST_IDLE      = 3'd0;
  localparam key_state_t ST_DEB_PRESS = 3'd1;
  localparam key_state_t ST_HELD      = 3'd2;
  localparam key_state_t ST_REPEAT    = 3'd3;
  localparam key_state_t ST_DEB_REL   = 3'd4;

  // Default timing at a 25 MHz pixel clock.
  localparam int DEB_CYCLES_DEF = 250000;    // 10 ms
  localparam int RPT_DELAY_DEF  = 12500000;  // 0.5 s
  localparam int RPT_RATE_DEF   = 2500000;   // 0.1 s

  // Counter width: ceil(log2) of the largest interval, at least 1 bit.
  // Counters only ever reach (interval - 1), so this width always suffices.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/key_repeat_fsm.sv
// rtl/key_repeat_fsm.sv - per-key debounce and auto-repeat state machine
// Purpose: turns one synchronized active-low key into single-cycle increment
//          pulses: one after press debounce, one at repeat entry, then one
//          every RPT_RATE cycles while held.
// Ports: clk_in - clock; rst - async active-low clear;
//        key_s - synchronized key (0 = pressed); inc - increment pulse.
module key_repeat_fsm
  import rgb_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int RPT_DELAY  = RPT_DELAY_DEF,
  parameter int RPT_RATE   = RPT_RATE_DEF,
  parameter int CNT_W      = cnt_width(DEB_CYCLES, RPT_DELAY, RPT_RATE)
) (
  input  logic clk_in,
  input  logic rst,
  input  logic key_s,
  output logic inc
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(RPT_RATE - 1);

  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_step;

  // Saturating step so the counter can never wrap back into range.
  assign cnt_step = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!key_s) begin
          state_d = ST_DEB_PRESS;
          cnt_d   = '0;
        end
      end
      ST_DEB_PRESS: begin
        if (key_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          inc     = 1'b1;
          state_d = ST_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_step;
        end
      end
      ST_HELD: begin
        if (key_s) begin
          state_d = ST_DEB_REL;
          cnt_d   = '0;
        end else if (cnt_q == DLY_LAST) begin
          inc     = 1'b1;
          state_d = ST_REPEAT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_step;
        end
      end
      ST_REPEAT: begin
        if (key_s) begin
          state_d = ST_DEB_REL;
          cnt_d   = '0;
        end else if (cnt_q == RATE_LAST) begin
          inc   = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_step;
        end
      end
      ST_DEB_REL: begin
        // A bounce back to pressed resumes holding without a new increment.
        if (!key_s) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_step;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/rgb_color_ctrl.sv
// rtl/rgb_color_ctrl.sv - three-key RGB intensity controller with frame-synced display
// Purpose: each key steps a 4-bit working intensity (mod 16) with debounce and
//          auto-repeat; all three working values are copied to the display
//          outputs together right after each vsync falling edge.
// Ports: clk_in - pixel clock; rst - async active-low clear;
//        key[2:0] - raw active-low keys (0 red, 1 blue, 2 green);
//        vsync - active-low vertical sync; ir/ib/ig - displayed intensities;
//        pending[2:0] - working value differs from displayed value.
module rgb_color_ctrl
  import rgb_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int RPT_DELAY  = RPT_DELAY_DEF,
  parameter int RPT_RATE   = RPT_RATE_DEF
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [2:0] key,
  input  logic       vsync,
  output logic [3:0] ir,
  output logic [3:0] ib,
  output logic [3:0] ig,
  output logic [2:0] pending
);

  localparam int CNT_W = cnt_width(DEB_CYCLES, RPT_DELAY, RPT_RATE);

  logic [2:0]      sync1_q, sync1_d;
  logic [2:0]      sync2_q, sync2_d;
  logic            vs_q, vs_d;
  logic [2:0][3:0] work_q, work_d;
  logic [2:0][3:0] disp_q, disp_d;
  logic [2:0]      inc;
  logic            load;

  for (genvar i = 0; i < 3; i++) begin : g_ch
    key_repeat_fsm #(
      .DEB_CYCLES (DEB_CYCLES),
      .RPT_DELAY  (RPT_DELAY),
      .RPT_RATE   (RPT_RATE),
      .CNT_W      (CNT_W)
    ) u_fsm (
      .clk_in (clk_in),
      .rst    (rst),
      .key_s  (sync2_q[i]),
      .inc    (inc[i])
    );
  end

  // Display loads from the registered working values, so an increment landing
  // on the load edge shows up one frame later.
  always_comb begin
    sync1_d = key;
    sync2_d = sync1_q;
    vs_d    = vsync;
    load    = vs_q & ~vsync;
    disp_d  = load ? work_q : disp_q;
    for (int i = 0; i < 3; i++) begin
      work_d[i]  = work_q[i] + {3'b000, inc[i]};
      pending[i] = (work_q[i] != disp_q[i]);
    end
  end

  assign ir = disp_q[RED];
  assign ib = disp_q[BLUE];
  assign ig = disp_q[GREEN];

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      vs_q    <= 1'b1;
      work_q  <= '0;
      disp_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      vs_q    <= vs_d;
      work_q  <= work_d;
      disp_q  <= disp_d;
    end
  end

endmodule

// File: tb/tb_rgb_color_ctrl.sv
// tb/tb_rgb_color_ctrl.sv - self-checking bench for rgb_color_ctrl
module tb_rgb_color_ctrl;

  logic       clk_in;
  logic       rst;
  logic [2:0] key;
  logic       vsync;
  logic [3:0] ir, ib, ig;
  logic [2:0] pending;

  int errors = 0;
  int checks = 0;
  int exp_r = 0, exp_b = 0, exp_g = 0;
  logic [11:0] sb_q[$];
  logic [11:0] sb_e;

  rgb_color_ctrl #(
    .DEB_CYCLES (4),
    .RPT_DELAY  (20),
    .RPT_RATE   (5)
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .key     (key),
    .vsync   (vsync),
    .ir      (ir),
    .ib      (ib),
    .ig      (ig),
    .pending (pending)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Hold one key low for n cycles, then release and wait out the release debounce.
  task automatic press(input int ch, input int n);
    key[ch] = 1'b0;
    repeat (n) tick();
    key[ch] = 1'b1;
    repeat (14) tick();
  endtask

  // Drive one vsync falling edge; the scoreboard entry is the model's view of
  // the working registers, which the display must hold after the load edge.
  task automatic frame(input string tag);
    sb_q.push_back({4'(exp_r), 4'(exp_b), 4'(exp_g)});
    vsync = 1'b0;
    tick();
    sb_e = sb_q.pop_front();
    check({tag, "_ir"}, int'(ir), int'(sb_e[11:8]));
    check({tag, "_ib"}, int'(ib), int'(sb_e[7:4]));
    check({tag, "_ig"}, int'(ig), int'(sb_e[3:0]));
    check({tag, "_pend"}, int'(pending), 0);
    vsync = 1'b1;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    key   = 3'b111;
    vsync = 1'b1;
    repeat (3) tick();
    check("rst_ir", int'(ir), 0);
    check("rst_ib", int'(ib), 0);
    check("rst_ig", int'(ig), 0);
    check("rst_pend", int'(pending), 0);
    rst = 1'b1;
    repeat (3) tick();

    // Clean red press: one increment, pending until the frame load.
    press(0, 10);
    exp_r = 1;
    check("red_pend", int'(pending), 1);
    check("red_ir_hold", int'(ir), 0);
    frame("red_load");

    // Bounced blue press followed by a stable low: one increment.
    key[1] = 1'b0; tick();
    key[1] = 1'b1; tick();
    key[1] = 1'b0; tick();
    key[1] = 1'b1; tick();
    key[1] = 1'b0;
    repeat (8) tick();
    key[1] = 1'b1;
    repeat (14) tick();
    exp_b = 1;
    check("blue_pend", int'(pending), 2);
    frame("blue_load");

    // Green held 50 cycles: press, repeat entry, then five repeats.
    press(2, 50);
    exp_g = 7;
    check("green_pend", int'(pending), 4);
    frame("green_load");

    // Red up to 15 across several frames, then wrap to 0 and continue.
    for (int i = 0; i < 14; i++) begin
      press(0, 10);
      exp_r = (exp_r + 1) % 16;
      if (i % 5 == 4) frame("red_step");
    end
    frame("red_15");
    press(0, 10);
    exp_r = (exp_r + 1) % 16;
    check("wrap_pend", int'(pending), 1);
    check("wrap_ir_hold", int'(ir), 15);
    frame("red_wrap0");
    press(0, 10);
    exp_r = (exp_r + 1) % 16;
    frame("red_after_wrap");

    // Increment landing on the load edge: display keeps the old value.
    key[0] = 1'b0;
    repeat (6) tick();
    vsync = 1'b0;
    sb_q.push_back({4'(exp_r), 4'(exp_b), 4'(exp_g)});
    tick();
    exp_r = (exp_r + 1) % 16;
    sb_e = sb_q.pop_front();
    check("coinc_ir_old", int'(ir), int'(sb_e[11:8]));
    check("coinc_pend", int'(pending), 1);
    vsync = 1'b1;
    repeat (4) tick();
    key[0] = 1'b1;
    repeat (14) tick();
    frame("coinc_next");

    // Reset while green is auto-repeating, key still held afterwards.
    key[2] = 1'b0;
    repeat (35) tick();
    rst = 1'b0;
    #1;
    exp_r = 0; exp_b = 0; exp_g = 0;
    sb_q.delete();
    check("mid_rst_ir", int'(ir), 0);
    check("mid_rst_ib", int'(ib), 0);
    check("mid_rst_ig", int'(ig), 0);
    check("mid_rst_pend", int'(pending), 0);
    tick(); tick();
    rst = 1'b1;
    repeat (6) tick();
    check("post_rst_no_early", int'(pending), 0);
    tick();
    exp_g = 1;
    check("post_rst_first_inc", int'(pending), 4);
    key[2] = 1'b1;
    repeat (14) tick();
    frame("post_rst_load");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
